laser: RTL and testbench

LASER -- requirements
Module: LASER

---
 rtl/laser.sv | 154 +++++++++++++++
 tb/tb_laser.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/laser.sv
// Two-circle coverage search: buffers 40 points, then alternately sweeps one
// circle center over the 16x16 grid while holding the other, until no gain.
module laser (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  output logic [3:0] C1X,
  output logic [3:0] C1Y,
  output logic [3:0] C2X,
  output logic [3:0] C2Y,
  output logic       DONE
);

  // state  | meaning
  // INPUT  | sample one point per cycle into the buffer
  // SWEEP1 | vary C1 over the grid (alone on the first sweep)
  // SWEEP2 | vary C2 over the grid with C1 held
  // FINISH | DONE pulse; point 0 of the next pattern is sampled here
  typedef enum logic [1:0] {INPUT, SWEEP1, SWEEP2, FINISH} state_t;

  localparam int NPTS = 40;

  state_t     state, state_nxt;
  logic [5:0] idx;
  logic [7:0] cnt;
  logic       first_sweep;
  logic       improved;
  logic [5:0] best_score;
  logic [5:0] score;
  logic       better;
  logic       use_fixed;
  logic [3:0] cand_x, cand_y, fix_x, fix_y;
  logic [3:0] px [NPTS];
  logic [3:0] py [NPTS];

  function automatic logic covers(input logic [3:0] ax, input logic [3:0] ay,
                                  input logic [3:0] bx, input logic [3:0] by);
    logic [3:0] dx, dy;
    logic [7:0] sx, sy;
    logic [8:0] d2;
    dx = (ax >= bx) ? ax - bx : bx - ax;
    dy = (ay >= by) ? ay - by : by - ay;
    sx = {4'd0, dx} * {4'd0, dx};
    sy = {4'd0, dy} * {4'd0, dy};
    d2 = {1'b0, sx} + {1'b0, sy};
    return d2 <= 9'd16;
  endfunction

  // Down-counter walks the grid; its complement gives the ascending scan index.
  assign cand_x = ~cnt[3:0];
  assign cand_y = ~cnt[7:4];

  always_comb begin
    fix_x     = C2X;
    fix_y     = C2Y;
    use_fixed = !first_sweep;
    if (state == SWEEP2) begin
      fix_x     = C1X;
      fix_y     = C1Y;
      use_fixed = 1'b1;
    end
    score = '0;
    for (int i = 0; i < NPTS; i++) begin
      score = score + {5'd0, covers(cand_x, cand_y, px[i], py[i]) |
                             (use_fixed & covers(fix_x, fix_y, px[i], py[i]))};
    end
    better = (state == SWEEP1 || state == SWEEP2) && (score > best_score);
  end

  always_comb begin
    state_nxt = state;
    DONE      = 1'b0;
    case (state)
      INPUT:  if (idx == 6'(NPTS - 1)) state_nxt = SWEEP1;
      SWEEP1: if (cnt == 8'd0) begin
                if (first_sweep || improved || better) state_nxt = SWEEP2;
                else                                   state_nxt = FINISH;
              end
      SWEEP2: if (cnt == 8'd0) begin
                if (improved || better) state_nxt = SWEEP1;
                else                    state_nxt = FINISH;
              end
      FINISH: begin
                DONE      = 1'b1;
                state_nxt = INPUT;
              end
      default: state_nxt = INPUT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= INPUT;
      idx         <= '0;
      cnt         <= 8'hFF;
      first_sweep <= 1'b0;
      improved    <= 1'b0;
      best_score  <= '0;
      C1X         <= '0;
      C1Y         <= '0;
      C2X         <= '0;
      C2Y         <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        INPUT: begin
          if (idx == 6'(NPTS - 1)) begin
            idx         <= '0;
            cnt         <= 8'hFF;
            first_sweep <= 1'b1;
            improved    <= 1'b0;
            best_score  <= '0;
            C1X         <= '0;
            C1Y         <= '0;
            C2X         <= '0;
            C2Y         <= '0;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        SWEEP1, SWEEP2: begin
          cnt <= cnt - 8'd1;
          if (better) begin
            best_score <= score;
            improved   <= 1'b1;
            if (state == SWEEP1) begin
              C1X <= cand_x;
              C1Y <= cand_y;
            end else begin
              C2X <= cand_x;
              C2Y <= cand_y;
            end
          end
          if (cnt == 8'd0) begin
            improved    <= 1'b0;
            first_sweep <= 1'b0;
          end
        end
        FINISH: idx <= 6'd1;
        default: idx <= '0;
      endcase
    end
  end

  // Point buffer carries no reset; it is fully rewritten before every sweep.
  always_ff @(posedge CLK) begin
    if (state == INPUT || state == FINISH) begin
      px[idx] <= X;
      py[idx] <= Y;
    end
  end

endmodule

// File: tb/tb_laser.sv
// Directed bench for laser: reset values, single and back-to-back patterns,
// and a reset pulse in the middle of the second sweep.
module tb_laser;
  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] X, Y;
  logic [3:0] C1X, C1Y, C2X, C2Y;
  logic       DONE;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [3:0] pat_x [40];
  logic [3:0] pat_y [40];

  laser dut (
    .CLK(CLK), .RST(RST), .X(X), .Y(Y),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (DONE === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_two(input logic [3:0] ax, input logic [3:0] ay, input int na,
                         input logic [3:0] bx, input logic [3:0] by);
    for (int i = 0; i < 40; i++) begin
      pat_x[i] = (i < na) ? ax : bx;
      pat_y[i] = (i < na) ? ay : by;
    end
  endtask

  // Called at a negedge; point 0 is sampled on the following posedge.
  task automatic drive(output logic saw_done, output logic [15:0] snap);
    saw_done = 1'b0;
    snap = '0;
    for (int i = 0; i < 40; i++) begin
      X = pat_x[i];
      Y = pat_y[i];
      @(negedge CLK);
      if (DONE !== 1'b0) saw_done = 1'b1;
      if (i == 0) snap = {C1X, C1Y, C2X, C2Y};
    end
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 50000 && !ok; n++) begin
      @(negedge CLK);
      if (DONE === 1'b1) ok = 1'b1;
    end
  endtask

  function automatic int cov(input int ax, input int ay, input int bx, input int by);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      int px, py;
      px = int'(pat_x[i]);
      py = int'(pat_y[i]);
      if ((ax-px)*(ax-px) + (ay-py)*(ay-py) <= 16 ||
          (bx-px)*(bx-px) + (by-py)*(by-py) <= 16) n++;
    end
    return n;
  endfunction

  task automatic check_result(input string tag, input logic [3:0] e1x, input logic [3:0] e1y,
                              input logic [3:0] e2x, input logic [3:0] e2y);
    chk({tag, "_c1x"}, C1X, e1x);
    chk({tag, "_c1y"}, C1Y, e1y);
    chk({tag, "_c2x"}, C2X, e2x);
    chk({tag, "_c2y"}, C2Y, e2y);
    chk({tag, "_cov"}, cov(C1X, C1Y, C2X, C2Y), 40);
  endtask

  logic        sd, ok;
  logic [15:0] snap;
  int          dc0;

  initial begin
    RST = 1'b0;
    X = '0;
    Y = '0;
    repeat (2) @(negedge CLK);
    chk("rst_done", DONE, 0);
    chk("rst_c1x", C1X, 0);
    chk("rst_c1y", C1Y, 0);
    chk("rst_c2x", C2X, 0);
    chk("rst_c2y", C2Y, 0);
    chk("rst_nox", $isunknown({C1X, C1Y, C2X, C2Y, DONE}), 0);

    // all points at (5,5): first grid cell reaching distance^2 = 16 is (5,1)
    set_two(4'd5, 4'd5, 40, 4'd0, 4'd0);
    RST = 1'b1;
    drive(sd, snap);
    chk("a_no_done_in_input", sd, 0);
    wait_done(ok);
    chk("a_done_seen", ok, 1);
    check_result("a", 4'd5, 4'd1, 4'd0, 4'd0);

    // back-to-back: 20 at (0,0), 20 at (15,15)
    set_two(4'd0, 4'd0, 20, 4'd15, 4'd15);
    drive(sd, snap);
    chk("b_no_done_in_input", sd, 0);
    chk("a_hold", snap, 16'h5100);
    chk("a_one_pulse", done_cnt, 1);
    wait_done(ok);
    chk("b_done_seen", ok, 1);
    check_result("b", 4'd0, 4'd0, 4'd15, 4'd11);

    // back-to-back again: C2 must restart from (0,0) for the new pattern
    set_two(4'd5, 4'd5, 40, 4'd0, 4'd0);
    drive(sd, snap);
    chk("c_no_done_in_input", sd, 0);
    chk("b_hold", snap, 16'h00FB);
    chk("b_one_pulse", done_cnt, 2);
    wait_done(ok);
    chk("c_done_seen", ok, 1);
    check_result("c", 4'd5, 4'd1, 4'd0, 4'd0);

    // 30 at (8,8), 10 at (0,15): C1=(8,4), C2=(0,11)
    set_two(4'd8, 4'd8, 30, 4'd0, 4'd15);
    drive(sd, snap);
    chk("d_no_done_in_input", sd, 0);
    wait_done(ok);
    chk("d_done_seen", ok, 1);
    check_result("d", 4'd8, 4'd4, 4'd0, 4'd11);

    // reset, send the two-cluster pattern, reset again during the second sweep
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    set_two(4'd0, 4'd0, 20, 4'd15, 4'd15);
    RST = 1'b1;
    drive(sd, snap);
    dc0 = done_cnt;
    repeat (300) @(negedge CLK);
    chk("e_no_early_done", done_cnt - dc0, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("e_rst_done", DONE, 0);
    chk("e_rst_centers", {C1X, C1Y, C2X, C2Y}, 0);
    RST = 1'b1;
    drive(sd, snap);
    chk("e_no_done_in_input", sd, 0);
    chk("e_no_done_after_abort", done_cnt - dc0, 0);
    wait_done(ok);
    chk("e_done_seen", ok, 1);
    check_result("e", 4'd0, 4'd0, 4'd15, 4'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
